// File: rtl/instr_encoder.sv
// Packs MIPS field tuples into 32-bit words, buffers them in a small FIFO and streams them into the IM write port.
// Optional tuple legality check enabled by defining INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        mem_full,
  output logic [10:0] word_cnt,
  output logic        enc_err
);

  // state  | meaning
  // IDLE   | nothing buffered, no write pending
  // STREAM | words buffered or a write pending toward IM
  // FULL   | IM_WORDS words written; stalled until reset/restart
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [10:0]    IM_WORDS_C = 11'(IM_WORDS);

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          im_we_q, im_we_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic [31:0]   im_addr_q, im_addr_d;
  logic [10:0]   word_cnt_q, word_cnt_d;

  logic [31:0] packed_word;
  logic        bad;
  logic        accept, enq, push, pop, bypass;
  logic        done, full_hit, can_load;

  always_comb begin
    packed_word = 32'h0;
    case (fmt)
      FMT_R:   packed_word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   packed_word = {opcode, rs, rt, imm16};
      FMT_J:   packed_word = {opcode, addr26};
      default: packed_word = 32'h0;
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  assign bad = ((fmt == FMT_R) && (opcode != 6'h00)) ||
               ((fmt == FMT_J) && (opcode != 6'h02) && (opcode != 6'h03));
`else
  assign bad = 1'b0;
`endif

  assign in_ready = (count_q < DEPTH_C) && (state_q != ST_FULL) && !restart;
  assign accept   = in_valid && in_ready;
  assign enq      = accept && !bad;

  assign done     = im_we_q && im_ready;
  assign full_hit = done && ((word_cnt_q + 11'd1) == IM_WORDS_C);
  // The completion that reaches the limit must not load a new word.
  assign can_load = (!im_we_q || im_ready) && (state_q != ST_FULL) && !full_hit;
  assign pop      = can_load && (count_q != '0);
  // An empty FIFO lets a fresh tuple go straight to the output register.
  assign bypass   = can_load && (count_q == '0) && enq;
  assign push     = enq && !bypass;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    im_we_d    = im_we_q;
    im_wdata_d = im_wdata_q;
    im_addr_d  = im_addr_q;
    word_cnt_d = word_cnt_q;

    if (restart) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      state_d    = ST_IDLE;
      im_we_d    = 1'b0;
      im_addr_d  = BASE_ADDR;
      word_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);

      if (done) begin
        im_addr_d  = im_addr_q + 32'd4;
        word_cnt_d = word_cnt_q + 11'd1;
      end

      if (pop) begin
        im_we_d    = 1'b1;
        im_wdata_d = fifo_q[rd_ptr_q];
      end else if (bypass) begin
        im_we_d    = 1'b1;
        im_wdata_d = packed_word;
      end else if (done) begin
        im_we_d    = 1'b0;
      end

      if (state_q == ST_FULL)             state_d = ST_FULL;
      else if (full_hit)                  state_d = ST_FULL;
      else if (count_d != '0 || im_we_d)  state_d = ST_STREAM;
      else                                state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      im_we_q    <= 1'b0;
      im_wdata_q <= 32'h0;
      im_addr_q  <= BASE_ADDR;
      word_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      im_we_q    <= im_we_d;
      im_wdata_q <= im_wdata_d;
      im_addr_q  <= im_addr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !restart && push) fifo_q[wr_ptr_q] <= packed_word;
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic enc_err_q;
  always_ff @(posedge clk) begin
    if (reset) enc_err_q <= 1'b0;
    else       enc_err_q <= accept && bad;
  end
  assign enc_err = enc_err_q;
`else
  assign enc_err = 1'b0;
`endif

  assign im_we    = im_we_q;
  assign im_wdata = im_wdata_q;
  assign im_addr  = im_addr_q;
  assign word_cnt = word_cnt_q;
  assign mem_full = (state_q == ST_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: default-size instance plus an IM_WORDS=4 instance for the limit case.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        restart, f_restart;
  logic        in_valid, f_in_valid;
  logic        in_ready, f_in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        im_we, f_im_we;
  logic        im_ready, f_im_ready;
  logic [31:0] im_addr, f_im_addr;
  logic [31:0] im_wdata, f_im_wdata;
  logic        mem_full, f_mem_full;
  logic [10:0] word_cnt, f_word_cnt;
  logic        enc_err, f_enc_err;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr;

  localparam logic [31:0] BASE = 32'h0000_3000;

  instr_encoder dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .addr26(addr26),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .mem_full(mem_full), .word_cnt(word_cnt), .enc_err(enc_err)
  );

  instr_encoder #(.IM_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .restart(f_restart),
    .in_valid(f_in_valid), .in_ready(f_in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .addr26(addr26),
    .im_we(f_im_we), .im_ready(f_im_ready), .im_addr(f_im_addr), .im_wdata(f_im_wdata),
    .mem_full(f_mem_full), .word_cnt(f_word_cnt), .enc_err(f_enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && im_we && im_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %h @%h expected none", im_wdata, im_addr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", im_addr, e[63:32]);
        chk("wr_data", im_wdata, e[31:0]);
      end
    end
  end

  task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] a);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm16 = imm; addr26 = a;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] a,
                      input logic [31:0] exp_word);
    bit ok;
    ok = 0;
    set_fields(f, op, s, t, d, sh, fn, imm, a);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back({exp_addr, exp_word});
      exp_addr += 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    sb.delete();
    exp_addr = BASE;
  endtask

  logic [31:0] burst_words [5] = '{32'h8FA10001, 32'h8FA20002, 32'h8FA30003,
                                  32'h8FA40004, 32'h8FA50005};

  initial begin
    int writes, accepts;
    reset = 1'b1; restart = 1'b0; f_restart = 1'b0;
    in_valid = 1'b0; f_in_valid = 1'b0; im_ready = 1'b0; f_im_ready = 1'b0;
    set_fields(2'b11, 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 6'h0, 16'h0, 26'h0);
    exp_addr = BASE;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_im_we", {31'h0, im_we}, 32'h0);
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_addr", im_addr, BASE);
    chk("rst_word_cnt", {21'h0, word_cnt}, 32'h0);
    chk("rst_mem_full", {31'h0, mem_full}, 32'h0);
    chk("rst_enc_err", {31'h0, enc_err}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // addu, first-word latency
    im_ready = 1'b1;
    send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FFFFFF, 32'h00221821);
    @(negedge clk);
    chk("lat_im_we", {31'h0, im_we}, 32'h1);
    chk("lat_wdata", im_wdata, 32'h00221821);
    chk("lat_addr", im_addr, BASE);
    drain();

    // ori then j from a fresh base
    @(posedge clk); #1;
    do_restart();
    send(2'b01, 6'h0D, 5'd0, 5'd1, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0, 32'h34011234);
    send(2'b10, 6'h02, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hBEEF, 26'h0000C00, 32'h08000C00);
    drain();

    // Back-pressure: register + 4 FIFO entries
    im_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(2'b01, 6'h23, 5'd29, 5'(i + 1), 5'd31, 5'd31, 6'h3F, 16'(i + 1), 26'h0, burst_words[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_wdata_hold", im_wdata, 32'h8FA10001);
      chk("bp_addr_hold", im_addr, 32'h00003008);
    end
    @(posedge clk); #1;
    im_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_word_cnt", {21'h0, word_cnt}, 32'd7);

    // Restart with queued words and a stalled write
    @(posedge clk); #1;
    im_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'b10, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'(i + 1), 32'h0C000000 | (i + 1));
    set_fields(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF);
    in_valid = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    restart = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    exp_addr = BASE;
    @(negedge clk);
    chk("rs_im_we", {31'h0, im_we}, 32'h0);
    chk("rs_addr", im_addr, BASE);
    chk("rs_word_cnt", {21'h0, word_cnt}, 32'h0);
    chk("rs_in_ready_after", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    im_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(2'b11, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h00000000);
    // Illegal-in-check-mode R tuple is encoded verbatim in the default build
    send(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 32'h20221821);
    @(negedge clk);
    chk("nochk_enc_err", {31'h0, enc_err}, 32'h0);
    drain();
    @(negedge clk);
    chk("rs_final_cnt", {21'h0, word_cnt}, 32'd2);

    // IM_WORDS=4 limit on the second instance
    @(posedge clk); #1;
    set_fields(2'b11, 6'h3F, 5'd5, 5'd5, 5'd5, 5'd5, 6'h3F, 16'hAAAA, 26'h155);
    f_im_ready = 1'b1;
    f_in_valid = 1'b1;
    writes = 0;
    accepts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (f_im_we && f_im_ready) begin
        writes++;
        chk("lim_nop_data", f_im_wdata, 32'h0);
      end
      if (f_in_valid && f_in_ready) accepts++;
      @(posedge clk); #1;
      if (accepts >= 6) f_in_valid = 1'b0;
    end
    f_in_valid = 1'b0;
    @(negedge clk);
    chk("lim_writes", writes, 32'd4);
    chk("lim_mem_full", {31'h0, f_mem_full}, 32'h1);
    chk("lim_word_cnt", {21'h0, f_word_cnt}, 32'd4);
    chk("lim_in_ready", {31'h0, f_in_ready}, 32'h0);
    chk("lim_im_we", {31'h0, f_im_we}, 32'h0);
    chk("lim_addr", f_im_addr, 32'h00003010);
    @(posedge clk); #1;
    f_restart = 1'b1;
    @(posedge clk); #1;
    f_restart = 1'b0;
    @(negedge clk);
    chk("lim_rs_addr", f_im_addr, BASE);
    chk("lim_rs_mem_full", {31'h0, f_mem_full}, 32'h0);
    chk("lim_rs_word_cnt", {21'h0, f_word_cnt}, 32'h0);
    chk("lim_rs_in_ready", {31'h0, f_in_ready}, 32'h1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
